// File: rtl/avalon_slave_mem_pkg.sv
// Shared constants for the Avalon-MM slave memory.
// Holds the bus widths and the default geometry and latency parameters.
package avalon_slave_mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = 2;

  localparam int unsigned DEPTH_DEF    = 4096;
  localparam int unsigned READ_LAT_DEF = 2;
  localparam int unsigned MAX_PEND_DEF = 4;

  // Bits needed to hold values 0..max inclusive.
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/resp_pipe.sv
// Read response pipeline: READ_LAT-deep valid/data shift register and the
// outstanding-read counter.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : a read was accepted this cycle
//   data_in      : read word, valid in the cycle after push (RAM output)
//   valid        : readdatavalid strobe, READ_LAT cycles after push
//   data         : returned word; holds last returned value otherwise
//   full         : outstanding count has reached MAX_PEND
module resp_pipe
  import avalon_slave_mem_pkg::*;
#(
  parameter int unsigned READ_LAT = READ_LAT_DEF,
  parameter int unsigned MAX_PEND = MAX_PEND_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              full
);

  localparam int unsigned CNT_W = cnt_width(MAX_PEND);

  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   hold_q;
  logic [DATA_W-1:0]   tail_data;
  logic                tail_vld;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = push;
  end

  assign tail_vld = vld_q[READ_LAT-1];

  // Stage 0 data is the RAM output register itself, so only READ_LAT-1
  // extra data registers are needed.
  if (READ_LAT == 1) begin : g_lat1
    assign tail_data = data_in;
  end else begin : g_latn
    logic [DATA_W-1:0] dat_q [READ_LAT-1];
    always_ff @(posedge clk) begin
      dat_q[0] <= data_in;
      for (int i = 1; i < int'(READ_LAT) - 1; i++) begin
        dat_q[i] <= dat_q[i-1];
      end
    end
    assign tail_data = dat_q[READ_LAT-2];
  end

  always_comb begin
    count_d = count_q;
    if (push && !tail_vld) begin
      count_d = count_q + 1'b1;
    end else if (!push && tail_vld) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
      if (tail_vld) begin
        hold_q <= tail_data;
      end
    end
  end

  assign valid = tail_vld;
  assign data  = tail_vld ? tail_data : hold_q;
  assign full  = (count_q == CNT_W'(MAX_PEND));

endmodule

// File: rtl/avalon_slave_mem.sv
// Avalon-MM slave backed by a single-port byte-enabled synchronous RAM with
// pipelined, fixed-latency reads.
// Ports:
//   clk, reset_n               : clock, asynchronous active-low reset
//   chipselect, read_n, write_n: transfer qualifiers (read/write active low)
//   address, byteenable        : word address, per-byte write enables
//   writedata                  : write data
//   waitrequest                : stall, only for reads when MAX_PEND reached
//   readdatavalid, readdata    : read return strobe and word
//   protocol_err               : sticky error (out-of-range or read+write)
module avalon_slave_mem
  import avalon_slave_mem_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned READ_LAT = READ_LAT_DEF,
  parameter int unsigned MAX_PEND = MAX_PEND_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [BE_W-1:0]   byteenable,
  input  logic [DATA_W-1:0] writedata,
  output logic              waitrequest,
  output logic              readdatavalid,
  output logic [DATA_W-1:0] readdata,
  output logic              protocol_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic              oob_q;
  logic              err_q, err_d;
  logic              full;
  logic              rd_req, wr_req, both_req;
  logic              rd_acc, wr_acc;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign rd_req   = chipselect && !read_n && write_n;
  assign wr_req   = chipselect && !write_n && read_n;
  assign both_req = chipselect && !read_n && !write_n;

  // Depends on read_n alone, not on chipselect, so a master never sees it
  // toggle with its own qualifier.
  assign waitrequest = full && !read_n;
  assign rd_acc      = rd_req && !waitrequest;
  assign wr_acc      = wr_req && !waitrequest;

  assign in_range = (address < ADDR_W'(DEPTH));
  assign idx      = address[IDX_W-1:0];

  // No reset on the array or its read register so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (byteenable[b]) begin
          mem[idx][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
    if (rd_acc) begin
      ram_q <= mem[idx];
    end
  end

  always_comb begin
    err_d = err_q;
    if (both_req || ((rd_acc || wr_acc) && !in_range)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oob_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (rd_acc) begin
        oob_q <= !in_range;
      end
    end
  end

  resp_pipe #(
    .READ_LAT (READ_LAT),
    .MAX_PEND (MAX_PEND)
  ) u_resp_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rd_acc),
    .data_in (oob_q ? '0 : ram_q),
    .valid   (readdatavalid),
    .data    (readdata),
    .full    (full)
  );

  assign protocol_err = err_q;

endmodule

// File: tb/tb_avalon_slave_mem.sv
// Bench for avalon_slave_mem: two instances (READ_LAT 2 and 8) share one
// stimulus stream and are each compared every cycle against a transaction
// model (memory array plus a due-cycle response FIFO per instance).
module tb_avalon_slave_mem;

  localparam int unsigned DEPTH    = 4096;
  localparam int unsigned LAT0     = 2;
  localparam int unsigned LAT1     = 8;
  localparam int unsigned MAX_PEND = 4;

  logic        clk;
  logic        reset_n;
  logic        cs, rn, wn;
  logic [31:0] addr;
  logic [1:0]  be;
  logic [15:0] wd;

  logic        wreq [2];
  logic        rdv  [2];
  logic [15:0] rdat [2];
  logic        perr [2];

  avalon_slave_mem #(
    .DEPTH    (DEPTH),
    .READ_LAT (LAT0),
    .MAX_PEND (MAX_PEND)
  ) u_dut0 (
    .clk           (clk),
    .reset_n       (reset_n),
    .chipselect    (cs),
    .read_n        (rn),
    .write_n       (wn),
    .address       (addr),
    .byteenable    (be),
    .writedata     (wd),
    .waitrequest   (wreq[0]),
    .readdatavalid (rdv[0]),
    .readdata      (rdat[0]),
    .protocol_err  (perr[0])
  );

  avalon_slave_mem #(
    .DEPTH    (DEPTH),
    .READ_LAT (LAT1),
    .MAX_PEND (MAX_PEND)
  ) u_dut1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .chipselect    (cs),
    .read_n        (rn),
    .write_n       (wn),
    .address       (addr),
    .byteenable    (be),
    .writedata     (wd),
    .waitrequest   (wreq[1]),
    .readdatavalid (rdv[1]),
    .readdata      (rdat[1]),
    .protocol_err  (perr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] mem_m  [DEPTH];
  int unsigned fdue   [2][16];
  logic [15:0] fdat   [2][16];
  int unsigned fhead  [2];
  int unsigned fcnt   [2];
  logic [15:0] last_m [2];
  logic        err_m  [2];

  int unsigned cyc;
  int unsigned n_total;
  int unsigned n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      fhead[k]  = 0;
      fcnt[k]   = 0;
      last_m[k] = 16'h0000;
      err_m[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int unsigned lat;
    int unsigned slot;
    logic        exp_wait;
    logic        exp_v;
    lat      = (k == 0) ? LAT0 : LAT1;
    exp_wait = (fcnt[k] == MAX_PEND) && !rn;
    check_eq($sformatf("waitrequest%0d", k), 32'(wreq[k]), 32'(exp_wait));
    exp_v = (fcnt[k] != 0) && (fdue[k][fhead[k]] == cyc);
    check_eq($sformatf("readdatavalid%0d", k), 32'(rdv[k]), 32'(exp_v));
    if (exp_v) begin
      check_eq($sformatf("readdata%0d", k), 32'(rdat[k]), 32'(fdat[k][fhead[k]]));
      last_m[k] = fdat[k][fhead[k]];
      fhead[k]  = (fhead[k] + 1) % 16;
      fcnt[k]--;
    end else begin
      check_eq($sformatf("readdata_hold%0d", k), 32'(rdat[k]), 32'(last_m[k]));
    end
    check_eq($sformatf("protocol_err%0d", k), 32'(perr[k]), 32'(err_m[k]));
    // Acceptance decisions for the edge that ends this cycle
    if (cs && !rn && wn && !exp_wait) begin
      slot           = (fhead[k] + fcnt[k]) % 16;
      fdue[k][slot]  = cyc + lat;
      fdat[k][slot]  = (addr < DEPTH) ? mem_m[addr[11:0]] : 16'h0000;
      fcnt[k]++;
      if (addr >= DEPTH) err_m[k] = 1'b1;
    end
    if (cs && !wn && rn && addr >= DEPTH) err_m[k] = 1'b1;
    if (cs && !rn && !wn) err_m[k] = 1'b1;
  endtask

  task automatic model_mem_write();
    if (cs && !wn && rn && addr < DEPTH) begin
      if (be[0]) mem_m[addr[11:0]][7:0]  = wd[7:0];
      if (be[1]) mem_m[addr[11:0]][15:8] = wd[15:8];
    end
  endtask

  task automatic cycle(input logic c, input logic r, input logic w, input logic [31:0] a,
                       input logic [1:0] b, input logic [15:0] d);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cs = c; rn = r; wn = w; addr = a; be = b; wd = d;
    cyc++;
    @(negedge clk);
    model_step(0);
    model_step(1);
    model_mem_write();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, 32'd0, 2'b00, 16'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] b, input logic [15:0] d);
    cycle(1'b1, 1'b1, 1'b0, a, b, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(1'b1, 1'b0, 1'b1, a, 2'b00, 16'h0);
  endtask

  // read_n held low (chipselect off) to show waitrequest stays low in reset.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      cs = 1'b0; rn = 1'b0; wn = 1'b1;
      cyc++;
      model_clear();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check_eq($sformatf("rst_waitrequest%0d", k), 32'(wreq[k]), 32'd0);
        check_eq($sformatf("rst_readdatavalid%0d", k), 32'(rdv[k]), 32'd0);
        check_eq($sformatf("rst_readdata%0d", k), 32'(rdat[k]), 32'd0);
        check_eq($sformatf("rst_protocol_err%0d", k), 32'(perr[k]), 32'd0);
      end
    end
  endtask

  initial begin
    int unsigned r;
    logic [31:0] a;
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    reset_n = 1'b0;
    cs = 1'b0; rn = 1'b1; wn = 1'b1; addr = '0; be = '0; wd = '0;
    model_clear();

    do_reset(3);

    // Preload the address window used by the random phase; the first write
    // lands on the first edge after release.
    for (int i = 0; i < 16; i++) wr(32'(i), 2'b11, 16'($urandom));

    // Byte-enabled overwrite then read-back
    wr(32'd5, 2'b11, 16'h1234);
    wr(32'd5, 2'b10, 16'hAB00);
    rd(32'd5);
    idle(10);

    // Streaming reads 0..9 of 100..109
    for (int i = 0; i < 10; i++) wr(32'(i), 2'b11, 16'(100 + i));
    for (int i = 0; i < 10; i++) rd(32'(i));
    idle(12);

    // Sustained read pressure: the long-latency instance must stall at 4
    for (int i = 0; i < 12; i++) rd(32'd3);
    idle(12);

    // Write then immediate read of same address, and a no-op byteenable
    wr(32'd7, 2'b11, 16'hC0DE);
    rd(32'd7);
    wr(32'd7, 2'b00, 16'hFFFF);
    rd(32'd7);
    idle(10);

    // Requests without chipselect are ignored
    cycle(1'b0, 1'b0, 1'b1, 32'd2, 2'b11, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'd2, 2'b11, 16'hDEAD);
    cycle(1'b0, 1'b0, 1'b0, 32'd2, 2'b11, 16'hBEEF);
    rd(32'd2);
    idle(10);

    // Simultaneous read and write: error, no transfer
    cycle(1'b1, 1'b0, 1'b0, 32'd2, 2'b11, 16'h5555);
    rd(32'd2);
    idle(10);

    // Reset with three reads in flight; contents must survive
    rd(32'd1);
    rd(32'd2);
    rd(32'd3);
    do_reset(2);
    idle(10);
    rd(32'd1);
    rd(32'd2);
    rd(32'd3);
    idle(10);

    // Out-of-range read, then a normal read; out-of-range write discarded
    rd(32'd4096);
    rd(32'd6);
    wr(32'd4096, 2'b11, 16'h9999);
    rd(32'd0);
    idle(10);

    // Randomized traffic with one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(2);
      r = $urandom_range(0, 19);
      a = ($urandom_range(0, 19) == 0) ? 32'(DEPTH + $urandom_range(0, 3)) :
                                          32'($urandom_range(0, 15));
      if (r < 9) begin
        cycle($urandom_range(0, 9) != 0, 1'b0, 1'b1, a, 2'($urandom), 16'($urandom));
      end else if (r < 18) begin
        cycle($urandom_range(0, 9) != 0, 1'b1, 1'b0, a, 2'($urandom), 16'($urandom));
      end else if (r == 18) begin
        cycle(1'b1, 1'b0, 1'b0, a, 2'($urandom), 16'($urandom));
      end else begin
        idle(1);
      end
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/avalon_slave_mem.md
AVALON_SLAVE_MEM -- requirements
Module: avalon_slave_mem

Interface
REQ-001 Parameter DEPTH, default 4096, number of 16-bit words held.
REQ-002 Parameter READ_LAT, default 2, cycles from read acceptance to readdatavalid (legal range 1..8).
REQ-003 Parameter MAX_PEND, default 4, maximum accepted-but-unreturned reads.
REQ-004 Clocking and reset SHALL be one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 chipselect  in  1  qualifies a transfer.
REQ-008 read_n  in  1  active-low read request.
REQ-009 write_n  in  1  active-low write request.
REQ-010 address  in  32  word address.
REQ-011 byteenable  in  2  bit1 = writedata[15:8], bit0 = writedata[7:0].
REQ-012 writedata  in  16  write data.
REQ-013 waitrequest  out  1  backpressure; master holds request while high.
REQ-014 readdatavalid  out  1  one-cycle strobe per returned read word.
REQ-015 readdata  out  16  read data, valid only with readdatavalid.
REQ-016 protocol_err  out  1  sticky error flag.

Function
REQ-017 Request present = chipselect=1 and exactly one of read_n or write_n low; acceptance = request present and waitrequest=0 in the same cycle.
REQ-018 waitrequest SHALL be combinational: high exactly when outstanding-read count equals MAX_PEND and read_n=0; writes are never stalled.
REQ-019 Accepted write at cycle N updates the enabled bytes of mem[address] at the end of cycle N; disabled bytes are unchanged; byteenable=00 is a legal no-op.
REQ-020 Accepted read at cycle N SHALL produce readdatavalid=1 at exactly N+READ_LAT, with readdata = mem[address] as of the end of cycle N.
REQ-021 Reads SHALL return strictly in acceptance order; one read accepted per cycle sustains one readdatavalid per cycle.
REQ-022 Outstanding count increments on read acceptance and decrements on readdatavalid; when both occur in the same cycle it is unchanged.
REQ-023 Write at N followed by read of the same address at N+1 SHALL return the written data.
REQ-024 address >= DEPTH: a write is accepted and discarded; a read is accepted and returns 16'h0000 with normal latency; both set protocol_err.
REQ-025 Both read_n and write_n low with chipselect=1: neither transfer is performed, no response is generated, protocol_err is set, and waitrequest follows REQ-018.
REQ-026 read_n or write_n low with chipselect=0 is ignored; no error is flagged.
REQ-027 protocol_err, once set, stays at 1 until reset.
REQ-028 readdata SHALL hold its last value when readdatavalid=0.

Reset
REQ-029 While reset_n=0: waitrequest=0, readdatavalid=0, readdata=16'h0000, protocol_err=0, outstanding count=0.
REQ-030 Reset asserted mid-operation discards all in-flight reads; no readdatavalid occurs for them after release.
REQ-031 Memory contents are not cleared by reset.
REQ-032 The first request is accepted on the first rising edge after reset_n deasserts.

Structure
REQ-033 A shared package SHALL hold DATA_W=16, ADDR_W=32, BE_W=2 and the default DEPTH, READ_LAT and MAX_PEND.
REQ-034 One sub-module, resp_pipe, SHALL implement the READ_LAT-deep valid/data shift pipeline and the outstanding counter.
REQ-035 The memory array SHALL be inferable as a single-port synchronous RAM with byte enables.

Verification
REQ-036 Write 0x1234 to addr 5 (be=11), then write 0xAB00 (be=10), then read addr 5 -> readdatavalid two cycles after the read is accepted, readdata=0xAB34.
REQ-037 Back-to-back reads of addrs 0..9, preloaded with values 100..109 -> ten consecutive readdatavalid strobes, in order, values 100..109.
REQ-038 READ_LAT=8, MAX_PEND=4, read_n held low for 12 cycles -> waitrequest high after the 4th acceptance; exactly 4 reads are in flight at a time; all requested reads are returned.
REQ-039 Read addr 4096 with DEPTH=4096 -> readdata=0x0000 at normal latency and protocol_err=1; a following valid read still succeeds.
REQ-040 read_n=0 and write_n=0 together -> no memory change, no readdatavalid, protocol_err=1.
REQ-041 Assert reset_n=0 with 3 reads pending -> no readdatavalid after release, memory contents intact, waitrequest=0.
